dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, data word width.
REQ-002 Parameter: ADDR_W, default 10, memory word-address width (1024 words).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 pN_req  in  1  request from port N (N=0 core MEM stage, N=1 DMA/loader).
REQ-006 pN_we  in  1  1=write, 0=read.
REQ-007 pN_addr  in  32  byte address.
REQ-008 pN_wdata  in  DATA_W  write data.
REQ-009 pN_gnt  out  1  one-cycle pulse: request accepted and being performed.
REQ-010 pN_rvalid  out  1  one-cycle pulse: transaction complete.
REQ-011 pN_rdata  out  DATA_W  read data, valid with pN_rvalid.
REQ-012 pN_err  out  1  with pN_rvalid: misaligned or out-of-range address, no access made.
REQ-013 mem_we  out  1  memory write enable.
REQ-014 mem_addr  out  ADDR_W  memory word address.
REQ-015 mem_wd  out  DATA_W  memory write data.
REQ-016 mem_rd  in  DATA_W  combinational memory read data for mem_addr.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP. At most one transaction is in flight.
REQ-019 Arbitration SHALL occur only in IDLE and RESP. Any sampled req moves the FSM to ACCESS. With no req: IDLE stays IDLE; RESP goes to IDLE.
REQ-020 The winner's we, addr and wdata SHALL be latched at the arbitration edge.
REQ-021 Round-robin: a single requester wins. If both request, the port not granted last wins. last_grant updates at each arbitration.
REQ-022 ACCESS: the granted pN_gnt=1 for exactly this cycle. mem_addr=latched addr[ADDR_W+1:2]. mem_wd=latched wdata.
REQ-023 In ACCESS, mem_we=latched we and no error; mem_we SHALL be 0 in every other state.
REQ-024 At the edge ending ACCESS, for a read the arbiter SHALL register mem_rd into the rdata register; the FSM then goes to RESP.
REQ-025 RESP: the granted pN_rvalid=1 for one cycle with pN_rdata. Writes also pulse rvalid, with rdata=0.
REQ-026 Latency: req sampled at edge k gives gnt in cycle k+1 and rvalid in cycle k+2. Back-to-back throughput is 1 transaction per 2 cycles (RESP->ACCESS).
REQ-027 Requester protocol: hold req, we, addr and wdata stable until gnt. Drop req at the edge ending the gnt cycle unless issuing a new request. A new request may be sampled in RESP.
REQ-028 Error: addr[1:0]!=0 or addr[31:ADDR_W+2]!=0 SHALL suppress mem_we and return rvalid with err=1 and rdata=0. Timing is unchanged.
REQ-029 The non-granted port's gnt, rvalid and err SHALL stay 0. Its req remains pending with no loss.
REQ-030 pN_rdata SHALL hold its last value outside rvalid cycles.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE and set all gnt, rvalid, err, mem_we, busy, mem_addr, mem_wd and rdata to 0.
REQ-032 Reset SHALL set last_grant=1, so that port 0 wins the first tie.
REQ-033 Reset during ACCESS SHALL abort the transaction. No write occurs after reset asserts, and no rvalid is issued for that transaction.

Structure
REQ-034 Shared package dmem_arb_pkg SHALL hold: the FSM state type (IDLE/ACCESS/RESP), the DATA_W/ADDR_W defaults and the port index constants PORT_CORE=0 and PORT_DMA=1.
REQ-035 The round-robin selection plus last_grant register SHALL be a sub-module rr_arbiter2 (inputs req[1:0], advance; output grant index).
REQ-036 RTL size target is 120-400 lines in total.

Verification
REQ-037 Single read: memory word 7=0xAB; p0 reads addr 0x1C. Expect p0_gnt in cycle k+1, then p0_rvalid with rdata=0xAB and err=0 in cycle k+2.
REQ-038 Write then read: p1 writes 0xDEADBEEF to 0x40, then reads 0x40. Expect mem_we for exactly one cycle with mem_addr=16, then rdata=0xDEADBEEF.
REQ-039 Contention: p0 and p1 both request continuously after reset. Expect grants in the order p0, p1, p0, p1, with gnt pulses 2 cycles apart.
REQ-040 Errors: p0 writes addr 0x1E, then addr 0x1000. Expect mem_we never asserted, and rvalid with err=1 and rdata=0 for each.
REQ-041 Reset in ACCESS during a p1 write: assert rst in that cycle. Expect mem_we=0 immediately, the target word unchanged, no p1_rvalid, and a later tie granted to p0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// FSM state type, default widths, port indices, address check helper.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Misaligned, or beyond the 2^aw word window.
  function automatic logic addr_bad(
    input logic [31:0] a,
    input int          aw
  );
    return (a[1:0] != 2'b00) ||
           ((a >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin selector with last-grant memory.
// Ports: clk, rst, req[1:0], advance (commit choice), grant (index).
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant
);

  logic last_grant;

  always_comb begin
    grant = last_grant;
    unique case (req)
      2'b01:   grant = PORT_CORE;
      2'b10:   grant = PORT_DMA;
      2'b11:   grant = ~last_grant;
      default: grant = last_grant;
    endcase
  end

  // Reset to the DMA port so the core wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DMA;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: core (p0) and DMA (p1) share one RAM port.
// Ports: pN_req/we/addr/wdata in, pN_gnt/rvalid/rdata/err out, mem_* bus, busy.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  output logic              busy
);

  state_t state;
  state_t state_nx;

  logic [1:0] req;
  logic       arb_ok;
  logic       advance;
  logic       win;

  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wd;

  logic              owner;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rd_new;

  assign req     = {p1_req, p0_req};
  assign arb_ok  = (state == IDLE) ||
                   (state == RESP);
  assign advance = arb_ok && (|req);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (win)
  );

  assign sel_we   = win ? p1_we    : p0_we;
  assign sel_addr = win ? p1_addr  : p0_addr;
  assign sel_wd   = win ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = advance ? ACCESS : IDLE;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = advance ? ACCESS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Writes and faulted accesses return zero data.
  assign rd_new = (we_q || err_q) ? '0 : mem_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= PORT_CORE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (advance) begin
        owner  <= win;
        we_q   <= sel_we;
        err_q  <= addr_bad(sel_addr, ADDR_W);
        addr_q <= sel_addr[ADDR_W+1:2];
        wd_q   <= sel_wd;
      end
      // Only the owner's data register moves; the other holds.
      if (state == ACCESS) begin
        if (owner == PORT_DMA) begin
          rdata1_q <= rd_new;
        end else begin
          rdata0_q <= rd_new;
        end
      end
    end
  end

  assign p0_gnt    = (state == ACCESS) &&
                     (owner == PORT_CORE);
  assign p1_gnt    = (state == ACCESS) &&
                     (owner == PORT_DMA);
  assign p0_rvalid = (state == RESP) &&
                     (owner == PORT_CORE);
  assign p1_rvalid = (state == RESP) &&
                     (owner == PORT_DMA);
  assign p0_err    = p0_rvalid && err_q;
  assign p1_err    = p1_rvalid && err_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

  assign mem_we   = (state == ACCESS) &&
                    we_q && !err_q;
  assign mem_addr = addr_q;
  assign mem_wd   = wd_q;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic.
// A transaction-level model predicts grants, responses and memory contents.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_req  [2];
  logic          r_we   [2];
  logic [31:0]   r_addr [2];
  logic [DW-1:0] r_wd   [2];

  logic          p0_gnt, p0_rvalid, p0_err;
  logic          p1_gnt, p1_rvalid, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  logic [DW-1:0] mem     [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .p0_req    (r_req[0]),
    .p0_we     (r_we[0]),
    .p0_addr   (r_addr[0]),
    .p0_wdata  (r_wd[0]),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p0_err    (p0_err),
    .p1_req    (r_req[1]),
    .p1_we     (r_we[1]),
    .p1_addr   (r_addr[1]),
    .p1_wdata  (r_wd[1]),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .p1_err    (p1_err),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .busy      (busy)
  );

  assign mem_rd = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
  end

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  bit            pg0 = 0, pg1 = 0;
  bit            ev = 0, ee = 0, ew = 0;
  int            ep = 0;
  logic [DW-1:0] ed = '0, ewd = '0;
  int            ewa = 0;
  int            last_w = 1;
  logic [DW-1:0] exp_rd [2];
  int            cyc = 0;
  int            we_cnt = 0;
  int            log_p [$];
  int            log_c [$];

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= (32'd4 << AW));
  endfunction

  task automatic predict(input bit free);
    int w;
    pg0 = 0;
    pg1 = 0;
    if (free && (r_req[0] || r_req[1])) begin
      if (r_req[0] && r_req[1]) w = 1 - last_w;
      else w = r_req[1] ? 1 : 0;
      last_w = w;
      pg0 = (w == 0);
      pg1 = (w == 1);
    end
  endtask

  always @(negedge clk) begin
    bit            g, nv, ne, nw, bad;
    int            w, np, nwa;
    logic [DW-1:0] nd, nwd;
    cyc++;
    if (mem_we) we_cnt++;
    if (rst) begin
      check("rst_gnt", {p1_gnt, p0_gnt}, 0);
      check("rst_rvalid", {p1_rvalid, p0_rvalid}, 0);
      check("rst_err", {p1_err, p0_err}, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wd", mem_wd, 0);
      check("rst_rdata0", p0_rdata, 0);
      check("rst_rdata1", p1_rdata, 0);
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      ev = 0;
      last_w = 1;
      predict(1);
    end else begin
      check("gnt", {p1_gnt, p0_gnt}, {pg1, pg0});
      g = pg0 | pg1;
      w = pg1 ? 1 : 0;
      nv = 0; np = 0; nd = '0; ne = 0;
      nw = 0; nwa = 0; nwd = '0;
      if (g) begin
        log_p.push_back(w);
        log_c.push_back(cyc);
        bad = is_bad(r_addr[w]);
        check("mem_we_acc", mem_we, r_we[w] && !bad);
        if (!bad) check("mem_addr", mem_addr, r_addr[w] / 4);
        check("mem_wd", mem_wd, r_wd[w]);
        nv = 1;
        np = w;
        ne = bad;
        nw = r_we[w] && !bad;
        nwa = r_addr[w] / 4;
        nwd = r_wd[w];
        nd = (r_we[w] || bad) ? '0 : ref_mem[nwa];
      end else begin
        check("mem_we_idle", mem_we, 0);
      end
      check("rvalid", {p1_rvalid, p0_rvalid},
            ev ? (ep == 1 ? 2'b10 : 2'b01) : 2'b00);
      check("err", {p1_err, p0_err},
            (ev && ee) ? (ep == 1 ? 2'b10 : 2'b01) : 2'b00);
      if (ev) begin
        exp_rd[ep] = ed;
        if (ew) ref_mem[ewa] = ewd;
      end
      check("rdata0", p0_rdata, exp_rd[0]);
      check("rdata1", p1_rdata, exp_rd[1]);
      check("busy", busy, g || ev);
      ev = nv; ep = np; ed = nd; ee = ne;
      ew = nw; ewa = nwa; ewd = nwd;
      predict(!g);
    end
  end

  task automatic issue(
    input  int            p,
    input  logic          we,
    input  logic [31:0]   a,
    input  logic [DW-1:0] d,
    output int            lat
  );
    bit got;
    @(posedge clk);
    #1;
    r_req[p] = 1'b1;
    r_we[p] = we;
    r_addr[p] = a;
    r_wd[p] = d;
    lat = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (p == 1 ? p1_gnt : p0_gnt) got = 1;
    end
    if (!got) begin
      check("gnt_timeout", got, 1);
      r_req[p] = 1'b0;
    end
  endtask

  task automatic drop(input int p);
    @(posedge clk);
    #1;
    r_req[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    int            lat, k;
    logic [31:0]   a;
    logic [DW-1:0] d;
    for (int t = 0; t < n; t++) begin
      k = $urandom_range(0, 7);
      if (k == 0) a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
      else if (k == 1) a = (32'd4 << AW) + ($urandom_range(0, 255) * 4);
      else a = $urandom_range(0, 15) * 4;
      d = $urandom;
      issue(p, $urandom_range(0, 1) == 1, a, d, lat);
      if ($urandom_range(0, 2) != 0) begin
        drop(p);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
    end
    drop(p);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            lat, c0;
    logic [DW-1:0] v, old;
    for (int i = 0; i < (1 << AW); i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    mem[7] = 32'hAB;
    ref_mem[7] = 32'hAB;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 0; r_we[p] = 0;
      r_addr[p] = '0; r_wd[p] = '0;
    end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;

    // Single read with nominal latency
    issue(0, 0, 32'h1C, '0, lat);
    check("rd_lat", lat, 2);
    drop(0);
    @(negedge clk);
    check("rd_rvalid", p0_rvalid, 1);
    check("rd_data", p0_rdata, 32'hAB);
    check("rd_err", p0_err, 0);

    // Write then read back on the DMA port
    c0 = we_cnt;
    issue(1, 1, 32'h40, 32'hDEADBEEF, lat);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 16);
    drop(1);
    @(negedge clk);
    check("wr_we_cnt", we_cnt - c0, 1);
    check("wr_rdata", p1_rdata, 0);
    issue(1, 0, 32'h40, '0, lat);
    drop(1);
    @(negedge clk);
    check("rb_rdata", p1_rdata, 32'hDEADBEEF);

    // Contention from reset
    do_reset();
    log_p.delete();
    log_c.delete();
    fork
      begin
        issue(0, 0, 32'h0, '0, lat);
        issue(0, 0, 32'h4, '0, lat);
        drop(0);
      end
      begin
        issue(1, 0, 32'h8, '0, lat);
        issue(1, 0, 32'hC, '0, lat);
        drop(1);
      end
    join
    @(negedge clk);
    check("rr_count", log_p.size(), 4);
    if (log_p.size() >= 4) begin
      check("rr_0", log_p[0], 0);
      check("rr_1", log_p[1], 1);
      check("rr_2", log_p[2], 0);
      check("rr_3", log_p[3], 1);
      for (int i = 1; i < 4; i++)
        check("rr_gap", log_c[i] - log_c[i-1], 2);
    end

    // Faulted addresses
    c0 = we_cnt;
    issue(0, 1, 32'h1E, 32'h55, lat);
    drop(0);
    @(negedge clk);
    check("mis_rvalid", p0_rvalid, 1);
    check("mis_err", p0_err, 1);
    check("mis_rdata", p0_rdata, 0);
    issue(0, 1, 32'h1000, 32'h66, lat);
    drop(0);
    @(negedge clk);
    check("oor_rvalid", p0_rvalid, 1);
    check("oor_err", p0_err, 1);
    check("oor_rdata", p0_rdata, 0);
    check("err_no_we", we_cnt - c0, 0);

    // Reset while a DMA write is in ACCESS
    old = mem[32];
    issue(1, 1, 32'h80, 32'h12345678, lat);
    #2;
    rst = 1'b1;
    r_req[0] = 1'b0;
    r_req[1] = 1'b0;
    #1;
    check("abort_mem_we", mem_we, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    check("abort_word", mem[32], old);
    log_p.delete();
    log_c.delete();
    fork
      begin issue(0, 0, 32'h80, '0, lat); drop(0); end
      begin issue(1, 0, 32'h84, '0, lat); drop(1); end
    join
    @(negedge clk);
    check("abort_tie", (log_p.size() > 0) ? log_p[0] : 9, 0);

    // Random concurrent traffic
    fork
      rand_port(0, 150);
      rand_port(1, 150);
    join
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
